// File: rtl/reg_file.sv
// Architectural register file x0..x31 with per-register rename tags (youngest in-flight ROB id).
// Optional macro REG_FILE_BYPASS_EN forwards a tag-matching commit to the read ports in the same cycle.
module reg_file (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush_in,
  input  logic        commit_enabled,
  input  logic [4:0]  commit_reg_id,
  input  logic [31:0] commit_data,
  input  logic [4:0]  commit_rob_id,
  input  logic        issue_enabled,
  input  logic [4:0]  issue_reg_id,
  input  logic [4:0]  issue_rob_id,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  output logic [31:0] rs1_value,
  output logic [31:0] rs2_value,
  output logic [4:0]  rs1_dep,
  output logic [4:0]  rs2_dep
);

  localparam int NUM_REGS = 32;

  logic [31:0] value_q [NUM_REGS];
  logic [31:0] value_d [NUM_REGS];
  logic [4:0]  dep_q   [NUM_REGS];
  logic [4:0]  dep_d   [NUM_REGS];

  logic [NUM_REGS-1:0] commit_sel;
  logic [NUM_REGS-1:0] issue_sel;
  logic [NUM_REGS-1:0] tag_clear;

  // Per-register write decode; x0 never matches so it stays at its reset value.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      if (gi == 0) begin : g_x0
        assign commit_sel[gi] = 1'b0;
        assign issue_sel[gi]  = 1'b0;
        assign tag_clear[gi]  = 1'b0;
      end else begin : g_xn
        assign commit_sel[gi] = commit_enabled && (commit_reg_id == 5'(gi));
        assign issue_sel[gi]  = issue_enabled && !flush_in && (issue_reg_id == 5'(gi));
        assign tag_clear[gi]  = commit_sel[gi] && (dep_q[gi] == commit_rob_id);
      end
    end
  endgenerate

  // Priority on the tag: flush, then a new issue, then retirement of the matching producer.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      value_d[r] = value_q[r];
      dep_d[r]   = dep_q[r];
      if (commit_sel[r]) begin
        value_d[r] = commit_data;
      end
      if (flush_in) begin
        dep_d[r] = 5'd0;
      end else if (issue_sel[r]) begin
        dep_d[r] = issue_rob_id;
      end else if (tag_clear[r]) begin
        dep_d[r] = 5'd0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        value_q[r] <= 32'd0;
        dep_q[r]   <= 5'd0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        value_q[r] <= value_d[r];
        dep_q[r]   <= dep_d[r];
      end
    end
  end

  logic fwd1;
  logic fwd2;

`ifdef REG_FILE_BYPASS_EN
  assign fwd1 = commit_enabled && (commit_reg_id == rs1_id) && (rs1_id != 5'd0) &&
                (dep_q[rs1_id] == commit_rob_id);
  assign fwd2 = commit_enabled && (commit_reg_id == rs2_id) && (rs2_id != 5'd0) &&
                (dep_q[rs2_id] == commit_rob_id);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    rs1_value = 32'd0;
    rs1_dep   = 5'd0;
    if (rs1_id != 5'd0) begin
      rs1_value = fwd1 ? commit_data : value_q[rs1_id];
      rs1_dep   = fwd1 ? 5'd0 : dep_q[rs1_id];
    end
  end

  always_comb begin
    rs2_value = 32'd0;
    rs2_dep   = 5'd0;
    if (rs2_id != 5'd0) begin
      rs2_value = fwd2 ? commit_data : value_q[rs2_id];
      rs2_dep   = fwd2 ? 5'd0 : dep_q[rs2_id];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomised scoreboard bench for reg_file: a behavioural model predicts every cycle's read ports.
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, commit_enabled, issue_enabled;
  logic [4:0]  commit_reg_id, commit_rob_id, issue_reg_id, issue_rob_id, rs1_id, rs2_id;
  logic [31:0] commit_data;
  logic [31:0] rs1_value, rs2_value;
  logic [4:0]  rs1_dep, rs2_dep;

  reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .commit_enabled(commit_enabled), .commit_reg_id(commit_reg_id),
    .commit_data(commit_data), .commit_rob_id(commit_rob_id),
    .issue_enabled(issue_enabled), .issue_reg_id(issue_reg_id), .issue_rob_id(issue_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1_dep(rs1_dep), .rs2_dep(rs2_dep)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [31:0] v1, v2;
    logic [4:0]  d1, d2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  logic [31:0] m_val [32];
  logic [4:0]  m_dep [32];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_val[r] = 0;
      m_dep[r] = 0;
    end
  endtask

  // Applies the inputs the DUT just sampled on a rising edge.
  task automatic model_edge();
    logic [4:0] old_dep;
    if (rst_in) begin
      model_reset();
      return;
    end
    if (commit_enabled && commit_reg_id != 0) begin
      old_dep = m_dep[commit_reg_id];
      m_val[commit_reg_id] = commit_data;
      if (old_dep == commit_rob_id) m_dep[commit_reg_id] = 0;
    end
    if (flush_in) begin
      for (int r = 0; r < 32; r++) m_dep[r] = 0;
    end else if (issue_enabled && issue_reg_id != 0) begin
      m_dep[issue_reg_id] = issue_rob_id;
    end
  endtask

  task automatic predict(input logic [4:0] id, output logic [31:0] v, output logic [4:0] d);
    v = 0;
    d = 0;
    if (id != 0) begin
      v = m_val[id];
      d = m_dep[id];
`ifdef REG_FILE_BYPASS_EN
      if (commit_enabled && commit_reg_id == id && m_dep[id] == commit_rob_id) begin
        v = commit_data;
        d = 0;
      end
`endif
    end
  endtask

  task automatic step(input logic rst, input logic fl,
                      input logic ce, input logic [4:0] cr, input logic [31:0] cd, input logic [4:0] cb,
                      input logic ie, input logic [4:0] ir, input logic [4:0] ib,
                      input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    @(posedge clk_in);
    #1;
    model_edge();
    cycle++;
    rst_in = rst; flush_in = fl;
    commit_enabled = ce; commit_reg_id = cr; commit_data = cd; commit_rob_id = cb;
    issue_enabled = ie; issue_reg_id = ir; issue_rob_id = ib;
    rs1_id = r1; rs2_id = r2;
    if (rst) model_reset();
    #1;
    e.cyc = cycle;
    predict(r1, e.v1, e.d1);
    predict(r2, e.v2, e.d2);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: read ports are sampled mid-cycle and compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rs1_value", e.cyc, rs1_value, e.v1);
        chk("rs1_dep",   e.cyc, 32'(rs1_dep), 32'(e.d1));
        chk("rs2_value", e.cyc, rs2_value, e.v2);
        chk("rs2_dep",   e.cyc, 32'(rs2_dep), 32'(e.d2));
        $display("cycle %0d rs1=%h/%0d rs2=%h/%0d", e.cyc, rs1_value, rs1_dep, rs2_value, rs2_dep);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  cr, cb, r1;
    logic [31:0] cd;
    rst_in = 1; flush_in = 0; commit_enabled = 0; commit_reg_id = 0; commit_data = 0;
    commit_rob_id = 0; issue_enabled = 0; issue_reg_id = 0; issue_rob_id = 0; rs1_id = 0; rs2_id = 0;
    model_reset();
    // Directed scenarios: reset, x0, rename/retire, younger producer, same-cycle, flush, bypass.
    step(1, 0, 0, 0, 0, 0,                 0, 0, 0,   5, 0);
    step(0, 0, 1, 0, 32'hDEADBEEF, 3,      1, 0, 3,   0, 0);
    step(0, 0, 0, 0, 0, 0,                 1, 5, 3,   0, 0);
    step(0, 0, 1, 5, 32'h1234, 3,          0, 0, 0,   5, 0);
    step(0, 0, 0, 0, 0, 0,                 1, 5, 3,   5, 0);
    step(0, 0, 0, 0, 0, 0,                 1, 5, 7,   5, 0);
    step(0, 0, 1, 5, 32'hAA, 3,            0, 0, 0,   5, 0);
    step(0, 0, 0, 0, 0, 0,                 1, 6, 4,   5, 6);
    step(0, 0, 1, 6, 32'h55, 4,            1, 6, 9,   6, 5);
    step(0, 0, 0, 0, 0, 0,                 1, 1, 2,   6, 0);
    step(0, 0, 0, 0, 0, 0,                 1, 2, 8,   1, 2);
    step(0, 1, 1, 1, 32'h77, 2,            1, 3, 10,  1, 2);
    step(0, 0, 0, 0, 0, 0,                 1, 7, 5,   1, 3);
    step(0, 0, 1, 7, 32'h99, 5,            0, 0, 0,   7, 2);
    step(0, 0, 0, 0, 0, 0,                 0, 0, 0,   7, 0);
    for (int n = 0; n < 3000; n++) begin
      cr = 5'($urandom_range(0, 31));
      cb = (m_dep[cr] != 0 && $urandom_range(0, 3) != 0) ? m_dep[cr] : 5'($urandom_range(1, 31));
      cd = $urandom;
      r1 = ($urandom_range(0, 1) == 1) ? cr : 5'($urandom_range(0, 31));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), cr, cd, cb,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
           r1, 5'($urandom_range(0, 31)));
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with per-register rename tags, sitting between the ROB commit port and the decoder. It holds the committed value of x0–x31 and, for each register, the ROB id of the youngest in-flight producer (0 = value is architectural and ready). Commits from the ROB write values and retire tags. Issue from the decoder installs new tags. A ROB flush discards all tags.

## Interface
- No parameters; widths fixed: 32 registers, 32-bit data, 5-bit ROB id (`ROB_RANGE`, valid ids 1..31, 0 = none).
- clk_in  input  1  system clock; all state updates on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- flush_in  input  1  ROB flush_outputs; clears all tags
- commit_enabled  input  1  ROB reg_file_enabled
- commit_reg_id  input  5  destination register of committed instruction
- commit_data  input  32  committed value
- commit_rob_id  input  5  ROB id of committed instruction
- issue_enabled  input  1  decoder dispatches an instruction with a register destination
- issue_reg_id  input  5  destination register being renamed
- issue_rob_id  input  5  ROB id allocated to it (ROB next_tail_output)
- rs1_id, rs2_id  input  5 each  source register selects
- rs1_value, rs2_value  output  32 each  register value
- rs1_dep, rs2_dep  output  5 each  pending producer ROB id, 0 if ready

## Operation
- State: value[0..31] (32 b), dep[0..31] (5 b).
- Reset (async, rst_in high): all value = 0, all dep = 0. Outputs then read 0/0 for every select.
- x0: writes and issues to register 0 are ignored; rs*_value = 0 and rs*_dep = 0 for id 0 always.
- Commit (commit_enabled, reg ≠ 0): value[reg] <= commit_data. The tag is cleared (dep[reg] <= 0) only if dep[reg] == commit_rob_id; otherwise a younger producer owns the register and the tag is kept.
- Issue (issue_enabled, reg ≠ 0, flush_in low): dep[reg] <= issue_rob_id.
- Same cycle, same register, commit and issue: value is written with commit_data. dep takes issue_rob_id; issue wins over the clear.
- Flush (flush_in high): every dep <= 0; issue is ignored. A commit in the same cycle still writes value. Values are never discarded by flush.
- Read: combinational from the selected register. rs*_dep = dep[rs*_id], rs*_value = value[rs*_id].
- Commit with commit_rob_id = 0 while enabled is illegal. The block writes the value and leaves tags untouched, since dep 0 equals 0 and the clear is a no-op.

## Timing
- Write latency: commit/issue/flush visible at outputs the cycle after the edge (see Configuration for same-cycle forwarding).
- No handshakes; every enabled input is consumed in the cycle presented. No backpressure.
- Read ports: purely combinational, zero-cycle, from registered state plus optional bypass.
- Reset mid-operation: asynchronous clear overrides any same-edge commit/issue/flush.

## Configuration
- REG_FILE_BYPASS_EN defined: same-cycle forwarding from the commit port. If commit_enabled, commit_reg_id == rs*_id ≠ 0 and dep[rs*_id] == commit_rob_id, then rs*_value = commit_data and rs*_dep = 0 in that cycle. Both ports are forwarded independently. No forwarding from the issue port.
- Undefined: reads reflect registered state only. A consumer sees the committed value and cleared tag one cycle after the commit edge.

## Test plan
- Reset, then read rs1_id=5, rs2_id=0 -> rs1_value=0, rs1_dep=0, rs2_value=0, rs2_dep=0. Issue/commit to x0 with data 0xDEADBEEF -> x0 still reads 0/0.
- Issue x5 rob 3 -> next cycle rs1_dep=3. Commit x5 rob 3 data 0x1234 -> next cycle rs1_value=0x1234, rs1_dep=0.
- Issue x5 rob 3, then issue x5 rob 7, then commit x5 rob 3 data 0xAA -> value=0xAA, dep stays 7.
- Same cycle: commit x6 rob 4 data 0x55 (dep[6]=4) and issue x6 rob 9 -> next cycle value=0x55, dep=9.
- Tags on x1 (rob 2), x2 (rob 8). Assert flush_in with issue x3 rob 10 and commit x1 rob 2 data 0x77 -> all deps 0, x1 value 0x77, x3 dep 0.
- With REG_FILE_BYPASS_EN: dep[7]=5, rs1_id=7, commit x7 rob 5 data 0x99 -> same cycle rs1_value=0x99, rs1_dep=0. Without the macro: same-cycle read shows the old value and dep 5; the next cycle shows 0x99/0.
